wb_coherence_ctrl: RTL
======================

# wb_coherence_ctrl

Write-hit coherence controller for the write-back cache path. It accepts write hits and marks the line dirty in a per-line dirty array. It then broadcasts an invalidate to remote caches over a bus_req/ack handshake and queues the modified line for write-back to main memory. It sits downstream of the cache hit/tag logic and upstream of the memory write port. It produces the dirty → invalidate → eventual clean sequence that the coherence assertions check.

## Interface
Parameters:
- ADDR_W, 10, line address width; dirty array has 2**ADDR_W entries
- DATA_W, 16, write data width
- WBQ_DEPTH, 4, write-back queue entries (power of two, ≥2)
- INV_TIMEOUT, 16, max cycles waiting for ack (used only with WB_INV_TIMEOUT_EN)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous active-high reset
- wr  in  1  write request
- cache_hit  in  1  qualifies wr as a hit
- addr_write  in  ADDR_W  write line address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  controller can accept a write hit
- bus_req  out  1  invalidate request to remote caches
- bus_addr  out  ADDR_W  address being invalidated
- ack  in  1  remote caches have invalidated bus_addr
- mem_wr_valid  out  1  write-back entry valid
- mem_wr_addr  out  ADDR_W  write-back address
- mem_wr_data  out  DATA_W  write-back data
- mem_wr_ready  in  1  memory accepts write-back
- dirty_rd_addr  in  ADDR_W  dirty lookup address
- dirty_rd  out  1  combinational dirty bit of dirty_rd_addr
- wbq_count  out  $clog2(WBQ_DEPTH)+1  queue occupancy
- inv_err  out  1  sticky invalidate timeout flag

## Operation
- FSM states: IDLE, INV_REQ, ENQ.
- IDLE: wr_ready=1. Accept when wr && cache_hit. Capture addr/data, set dirty[addr], go INV_REQ. wr && !cache_hit is ignored (misses are handled elsewhere).
- INV_REQ: bus_req=1, bus_addr=captured addr, held stable until ack. On ack, go ENQ. ack while bus_req=0 is ignored.
- ENQ: push {addr,data} when queue not full, then go IDLE. If the queue is full, stay in ENQ.
- Queue head drives mem_wr_*. Pop on mem_wr_valid && mem_wr_ready.
- On pop, clear dirty[popped addr] unless either of these holds:
  - another queue entry has the same addr;
  - the FSM is not IDLE with captured addr equal to the popped addr.
- A set and a clear of the same dirty bit in the same cycle: set wins.
- Simultaneous push and pop when full: push waits. Simultaneous push and pop when not full: both occur, count unchanged.
- Queue pointers wrap modulo WBQ_DEPTH.

## Timing
- Reset values: wr_ready=1, bus_req=0, bus_addr=0, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, wbq_count=0, inv_err=0, all dirty bits 0, state IDLE.
- Accept at edge N: dirty_rd=1 for that addr and bus_req=1 from N+1; wr_ready=0 from N+1.
- ack sampled at edge M (M ≥ N+1): bus_req=0 from M+1. Push at M+1 if not full, so mem_wr_valid=1 from M+2 at earliest and wr_ready=1 from M+2.
- Minimum accept-to-accept spacing: 3 cycles (ack at first request cycle).
- Reset mid-operation: in-flight capture and queue contents are discarded, all outputs return to reset values next cycle.

## Configuration
- WB_INV_TIMEOUT_EN defined: a counter runs in INV_REQ.
  - If ack is absent for INV_TIMEOUT cycles, drop bus_req, set inv_err (sticky until reset) and proceed to ENQ.
  - The write-back still occurs.
- WB_INV_TIMEOUT_EN undefined: INV_REQ waits indefinitely, no counter is built, inv_err is tied 0.

## Structure
- Package wb_coh_pkg: state enum, wbq entry struct {addr, data} parameterised by ADDR_W/DATA_W via typedefs, INVALIDATE/DIRTY encoding constants.
- Sub-module wb_fifo: synchronous FIFO with push/pop/full/empty/count. It exposes all entry addresses for the dirty-clear match.
- FSM and dirty array live in the top module.

## Test plan
- Reset, then wr=1, cache_hit=1, addr=0x005, data=0x0042, ack one cycle after bus_req → dirty_rd(0x005)=1 at N+1; bus_req for one cycle with bus_addr=0x005; mem_wr 0x005/0x0042 at M+2; after the pop with mem_wr_ready=1, dirty_rd(0x005)=0.
- wr=1, cache_hit=0, addr=0x010 → no bus_req, dirty_rd(0x010)=0, wr_ready stays 1.
- mem_wr_ready=0, five hits to 0x001..0x005 with immediate ack:
  - wbq_count reaches 4;
  - the fifth stalls in ENQ with wr_ready=0;
  - raising mem_wr_ready drains in order 0x001..0x005.
- Two hits to 0x020 (data 0x0001 then 0x0002) queued. Pop the first → dirty_rd(0x020) stays 1. Pop the second → 0.
- With WB_INV_TIMEOUT_EN and ack held 0 for 16 cycles → bus_req drops, inv_err=1 and stays 1, entry still written back.
- Assert reset while in INV_REQ with 2 queued entries → next cycle: bus_req=0, mem_wr_valid=0, wbq_count=0, all dirty bits 0.

Source files
------------

// File: rtl/wb_coh_pkg.sv
// wb_coh_pkg: shared definitions for the write-hit coherence controller.
//   - wb_state_e : controller FSM states (IDLE, INV_REQ, ENQ)
//   - INVALIDATE : level driven on bus_req while an invalidate is outstanding
//   - DIRTY/CLEAN: encoding of one entry of the per-line dirty array
// The {addr, data} write-back entry type depends on module parameters, so it
// is declared as a typedef inside the modules that use it.
package wb_coh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INV_REQ = 2'd1,
        ST_ENQ     = 2'd2
    } wb_state_e;

    localparam logic INVALIDATE = 1'b1;
    localparam logic DIRTY      = 1'b1;
    localparam logic CLEAN      = 1'b0;

endpackage

// File: rtl/wb_coherence_ctrl_if.sv
// wb_coherence_ctrl_if: bus-side signals of the coherence controller.
//   write hit : wr, cache_hit, addr_write, wr_data -> wr_ready
//   invalidate: bus_req, bus_addr -> ack
//   write-back: mem_wr_valid, mem_wr_addr, mem_wr_data -> mem_wr_ready
// Modport slave is the controller view, master is the environment view.
interface wb_coherence_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              wr;
    logic              cache_hit;
    logic [ADDR_W-1:0] addr_write;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              ack;
    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ready;

    modport slave (
        input  wr, cache_hit, addr_write, wr_data, ack, mem_wr_ready,
        output wr_ready, bus_req, bus_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport master (
        output wr, cache_hit, addr_write, wr_data, ack, mem_wr_ready,
        input  wr_ready, bus_req, bus_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous write-back queue of {addr, data} entries.
// Ports: clk, reset (sync, active-high); push_i/push_addr_i/push_data_i;
// pop_i; head_addr_o/head_data_o; full_o, empty_o, count_o;
// entry_addr_o (all slots) and other_valid_o (occupied slots except the head),
// used by the controller to find other queued copies of the head address.
// A push while full and a pop while empty are ignored.
module wb_fifo #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_o,
    output logic [DEPTH-1:0]             other_valid_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]               count_q, count_d;
    logic                         do_push_s, do_pop_s;
    logic [PTR_W-1:0]             offset_s;

    // Next-state of storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        full_o    = (count_q == FULL_CNT);
        empty_o   = (count_q == {(PTR_W+1){1'b0}});
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            addr_d[wr_ptr_q] = push_addr_i;
            data_d[wr_ptr_q] = push_data_i;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Occupied slots other than the head: slot offset from rd_ptr in 1..count-1.
    always_comb begin
        offset_s      = {PTR_W{1'b0}};
        other_valid_o = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offset_s         = PTR_W'(i) - rd_ptr_q;
            other_valid_o[i] = (offset_s != {PTR_W{1'b0}}) && ({1'b0, offset_s} < count_q);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign count_o      = count_q;
    assign entry_addr_o = addr_q;

endmodule

// File: rtl/wb_coherence_ctrl.sv
// wb_coherence_ctrl: write-hit coherence controller for the write-back path.
// A write hit marks its line dirty, an invalidate is broadcast on bus_req/ack,
// then {addr, data} is queued for write-back; the dirty bit is cleared when the
// last pending copy of that line leaves the queue.
// Ports: clk, reset (sync, active-high); bus (wb_coherence_ctrl_if.slave:
// write hit, invalidate and write-back handshakes); dirty_rd_addr/dirty_rd
// (combinational dirty lookup); wbq_count (queue occupancy); inv_err (sticky
// invalidate timeout).
// Optional feature macro WB_INV_TIMEOUT_EN: abandon a waiting invalidate after
// INV_TIMEOUT cycles, flag inv_err and still write the line back. Without it
// INV_REQ waits for ack indefinitely and inv_err is 0.
module wb_coherence_ctrl
    import wb_coh_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int WBQ_DEPTH   = 4,
    parameter int INV_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    wb_coherence_ctrl_if.slave         bus,
    input  logic [ADDR_W-1:0]          dirty_rd_addr,
    output logic                       dirty_rd,
    output logic [$clog2(WBQ_DEPTH):0] wbq_count,
    output logic                       inv_err
);
    localparam int LINES = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

    if (INV_TIMEOUT < 1 || WBQ_DEPTH < 2) begin : g_bad_params
        $error("wb_coherence_ctrl: INV_TIMEOUT must be >= 1 and WBQ_DEPTH >= 2");
    end

    wb_state_e                     state_q, state_d;
    wbq_entry_t                    cap_q, cap_d;
    logic [LINES-1:0]              dirty_q, dirty_d;
    logic                          wr_ready_s, bus_req_s, accept_s, push_s, pop_s;
    logic                          full_s, empty_s, keep_s, timeout_s;
    logic [ADDR_W-1:0]             head_addr_s;
    logic [DATA_W-1:0]             head_data_s;
    logic [WBQ_DEPTH-1:0][ADDR_W-1:0] entry_addr_s;
    logic [WBQ_DEPTH-1:0]          other_valid_s, other_hit_s;

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(WBQ_DEPTH)) u_wbq (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_addr_i  (cap_q.addr),
        .push_data_i  (cap_q.data),
        .pop_i        (pop_s),
        .head_addr_o  (head_addr_s),
        .head_data_o  (head_data_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .count_o      (wbq_count),
        .entry_addr_o (entry_addr_s),
        .other_valid_o(other_valid_s)
    );

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wr && bus.cache_hit) state_d = ST_INV_REQ;
                else                         state_d = ST_IDLE;
            end
            ST_INV_REQ: begin
                if (bus.ack || timeout_s) state_d = ST_ENQ;
                else                      state_d = ST_INV_REQ;
            end
            ST_ENQ: begin
                if (!full_s) state_d = ST_IDLE;
                else         state_d = ST_ENQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state only.
    always_comb begin
        wr_ready_s = 1'b0;
        bus_req_s  = 1'b0;
        accept_s   = 1'b0;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready_s = 1'b1;
                accept_s   = bus.wr && bus.cache_hit;
            end
            ST_INV_REQ: bus_req_s = INVALIDATE;
            ST_ENQ:     push_s    = !full_s;
            default:    wr_ready_s = 1'b0;
        endcase
    end

    // Capture register and dirty array update. A line stays dirty on pop while
    // another copy is queued or still in flight in the FSM; a set in the same
    // cycle overrides the clear.
    always_comb begin
        pop_s = !empty_s && bus.mem_wr_ready;
        if (accept_s) cap_d = '{addr: bus.addr_write, data: bus.wr_data};
        else          cap_d = cap_q;
        for (int i = 0; i < WBQ_DEPTH; i++) begin
            other_hit_s[i] = other_valid_s[i] && (entry_addr_s[i] == head_addr_s);
        end
        keep_s  = (|other_hit_s) || ((state_q != ST_IDLE) && (cap_q.addr == head_addr_s));
        dirty_d = dirty_q;
        if (pop_s && !keep_s) dirty_d[head_addr_s] = CLEAN;
        else                  dirty_d[head_addr_s] = dirty_q[head_addr_s];
        if (accept_s) dirty_d[bus.addr_write] = DIRTY;
        else          dirty_d[bus.addr_write] = dirty_d[bus.addr_write];
    end

    // State, capture and dirty registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            dirty_q <= dirty_d;
        end
    end

`ifdef WB_INV_TIMEOUT_EN
    localparam int TO_W = $clog2(INV_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(INV_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            inv_err_q, inv_err_d;

    // Counts un-acked INV_REQ cycles; fires on the INV_TIMEOUT-th one.
    always_comb begin
        timeout_s = 1'b0;
        to_cnt_d  = {TO_W{1'b0}};
        if (state_q == ST_INV_REQ && !bus.ack) begin
            if (to_cnt_q == TO_LAST) begin
                timeout_s = 1'b1;
                to_cnt_d  = {TO_W{1'b0}};
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1'b1);
            end
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
        inv_err_d = inv_err_q | timeout_s;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= {TO_W{1'b0}};
            inv_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            inv_err_q <= inv_err_d;
        end
    end

    assign inv_err = inv_err_q;
`else
    assign timeout_s = 1'b0;
    assign inv_err   = 1'b0;
`endif

    assign bus.wr_ready     = wr_ready_s;
    assign bus.bus_req      = bus_req_s;
    assign bus.bus_addr     = cap_q.addr;
    assign bus.mem_wr_valid = !empty_s;
    assign bus.mem_wr_addr  = head_addr_s;
    assign bus.mem_wr_data  = head_data_s;
    assign dirty_rd         = dirty_q[dirty_rd_addr];

endmodule
